sap1_sequencer: RTL and testbench
=================================

Name: sap1_sequencer

Overview:
- Controller-sequencer for the 8-bit SAP-style datapath (PC, MAR, RAM, IR, A, ALU, B, output register).
- Advances a one-hot six-state T-state ring on the falling edge of clk and decodes the IR opcode nibble into the 12-bit active-mixed control word.
- Adds run/single-step control and halt.
- Sits between the IR upper nibble and every load/enable pin of the datapath; the datapath itself updates on the rising edge of clk.

Parameters:
- OUT_OPCODE, 4'hE, opcode of the OUT instruction.
- HLT_OPCODE, 4'hF, opcode of the HLT instruction.
- IDLE_CON, 12'h3E3, control word with every signal inactive.

Ports:
- clk  input  1  system clock; the sequencer updates on the falling edge.
- clr  input  1  asynchronous reset, active-low.
- opcode  input  4  IR[7:4], valid from the rising edge inside T3 onward.
- run  input  1  1 = free-running sequencing, 0 = paused.
- step  input  1  single-step request, level input; a 0->1 transition sampled on falling edges advances one T-state while run=0.
- con  output  12  control word {Cp,Ep,Lm_n,CE_n,Li_n,Ei_n,La_n,Ea,Su,Eu,Lb_n,Lo_n}, bit 11 first.
- tstate  output  6  one-hot ring, bit0=T1 … bit5=T6; 0 = not started.
- halted  output  1  high once HLT is decoded.
- cycle_end  output  1  high during the last T-state of each instruction.

Behaviour:
- Reset (clr=0, asynchronous):
  - tstate=6'b000000, halted=0, con=IDLE_CON, cycle_end=0.
  - Internal opcode latch=4'h0, step edge detector cleared.
- Advance condition, evaluated on each falling edge: adv = !halted & (run | step_rise), where step_rise = step & !step_q.
  - step_q is registered on every falling edge.
  - step is ignored while run=1.
- Ring update on a falling edge with adv:
  - 0 -> T1.
  - Tn -> Tn+1.
  - T6 -> T1.
  - No adv: hold.
- Opcode latch: captured on the falling edge that moves T3->T4. Decode in T4..T6 uses only the latched value.
- Control word by state (con is combinational from the registered state, so there is no extra latency):
  - T1 = 5E3: Ep, Lm.
  - T2 = BE3: Cp.
  - T3 = 263: CE, Li.
  - LDA (0000): T4=1A3, T5=2C3, T6=3E3.
  - ADD (0001): T4=1A3, T5=2E1, T6=3C7.
  - SUB (0010): T4=1A3, T5=2E1, T6=3CF.
  - OUT: T4=3F2, T5=3E3, T6=3E3.
  - HLT: T4=3E3; halted set on the falling edge leaving T4; ring freezes at T5.
  - Any other opcode: NOP, IDLE_CON in T4..T6.
- Pause gating:
  - When the next falling edge will not advance (run=0 and no pending step, or halted=1), con=IDLE_CON. This keeps the datapath from re-loading or re-incrementing on repeated rising edges.
  - During the cycle granted by a step edge, con shows the decoded word for exactly one rising edge.
- halted is sticky. Only clr clears it. While halted: tstate frozen, con=IDLE_CON, cycle_end=0.
- cycle_end is high in T6, or in the early-exit state when the optional feature is compiled in.
- Simultaneous events:
  - clr overrides everything.
  - A step edge arriving with run=1 is not counted as an extra advance.
  - A run 1->0 transition mid-instruction freezes the ring at its current T-state; resuming continues from that state.
- Reset mid-instruction: immediate return to the reset values. The partial instruction is abandoned and the datapath PC is not touched by the sequencer.

Optional Feature:
- Macro: VAR_CYCLE_EN.
- Defined: variable-length machine cycle.
  - LDA returns T5->T1.
  - OUT and NOP return T4->T1.
  - ADD and SUB keep T6->T1.
  - cycle_end is high in the returning state.
  - HLT is unchanged.
- Undefined: every instruction takes the fixed six T-states.

Test Plan:
1. Reset, then clr=1, run=1, opcode=0000 -> tstate 01,02,04,08,10,20,01 on successive falling edges; con=5E3,BE3,263,1A3,2C3,3E3.
2. opcode=0010 with run=1 -> T5 con=2E1, T6 con=3CF, cycle_end=1 only in T6.
3. opcode=4'hF -> halted rises after T4; tstate stays 6'b010000 for 20 cycles, con=3E3; step pulses have no effect; clr pulse -> tstate=0, halted=0.
4. run=0 at T2, three step pulses each one cycle wide -> ring T2->T3->T4->T5, one state per pulse; con=3E3 except in each granted cycle; holding step high advances only once.
5. clr asserted asynchronously mid-T5 of ADD -> tstate=0 and con=3E3 before the next clock edge.
6. VAR_CYCLE_EN defined, opcode=4'hE -> T4 con=3F2, cycle_end=1, next state T1; opcode=0000 -> T5 to T1; an ADD instruction still takes 6 states.

Source files
------------

// File: rtl/sap1_sequencer.sv
// rtl/sap1_sequencer.sv - SAP-1 controller-sequencer: T-state ring, opcode decode, run/step/halt
//
// Purpose:
//   Drives every load/enable pin of the 8-bit SAP datapath. A one-hot six-state
//   T-state ring advances on the falling edge of clk, so the control word is stable
//   around the rising edge where the datapath registers update.
//
// Ports:
//   clk       - system clock; sequencer state changes on the falling edge
//   clr       - asynchronous reset, active-low
//   opcode    - IR[7:4], valid from the rising edge inside T3 onward
//   run       - 1 = free-running, 0 = paused (single-step via step)
//   step      - level input; a 0->1 transition advances one T-state while run=0
//   con       - {Cp,Ep,Lm_n,CE_n,Li_n,Ei_n,La_n,Ea,Su,Eu,Lb_n,Lo_n}
//   tstate    - one-hot ring, bit0=T1 .. bit5=T6; 0 = not started
//   halted    - sticky, set once HLT is decoded
//   cycle_end - high during the last T-state of each instruction
//
// Configuration:
//   VAR_CYCLE_EN - variable-length machine cycle (LDA ends at T5, OUT/NOP at T4).

module sap1_sequencer #(
  parameter logic [3:0]  OUT_OPCODE = 4'hE,
  parameter logic [3:0]  HLT_OPCODE = 4'hF,
  parameter logic [11:0] IDLE_CON   = 12'h3E3
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [3:0]  opcode,
  input  logic        run,
  input  logic        step,
  output logic [11:0] con,
  output logic [5:0]  tstate,
  output logic        halted,
  output logic        cycle_end
);

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;

  typedef enum logic [5:0] {
    S_T0 = 6'b000000,
    S_T1 = 6'b000001,
    S_T2 = 6'b000010,
    S_T3 = 6'b000100,
    S_T4 = 6'b001000,
    S_T5 = 6'b010000,
    S_T6 = 6'b100000
  } tstate_t;

  tstate_t     r_state;
  logic        r_halted;
  logic [3:0]  r_op;
  logic        r_step_q;

  tstate_t     w_next;
  logic        w_halt_next;
  logic [3:0]  w_op_next;
  logic [11:0] w_con_dec;
  logic        w_last;
  logic        w_step_rise;
  logic        w_adv;

  always_ff @(negedge clk or negedge clr) begin
    if (!clr) begin
      r_state  <= S_T0;
      r_halted <= 1'b0;
      r_op     <= 4'h0;
      r_step_q <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_halted <= w_halt_next;
      r_op     <= w_op_next;
      r_step_q <= step;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_halt_next = r_halted;
    w_op_next   = r_op;
    w_con_dec   = IDLE_CON;
    w_last      = 1'b0;
    // step only matters while paused; with run=1 the advance happens anyway
    w_step_rise = step & ~r_step_q;
    w_adv       = ~r_halted & (run | w_step_rise);

    case (r_state)
      S_T1: begin
        w_con_dec = 12'h5E3;
        w_next    = S_T2;
      end
      S_T2: begin
        w_con_dec = 12'hBE3;
        w_next    = S_T3;
      end
      S_T3: begin
        w_con_dec = 12'h263;
        w_next    = S_T4;
        // IR is loaded on the rising edge inside T3, so it is valid here
        w_op_next = opcode;
      end
      S_T4: begin
        w_next = S_T5;
        if (r_op == OP_LDA || r_op == OP_ADD || r_op == OP_SUB) begin
          w_con_dec = 12'h1A3;
        end else if (r_op == OUT_OPCODE) begin
          w_con_dec = 12'h3F2;
`ifdef VAR_CYCLE_EN
          w_last = 1'b1;
          w_next = S_T1;
`endif
        end else if (r_op == HLT_OPCODE) begin
          // ring stops at T5 because halted blocks every later advance
          w_halt_next = 1'b1;
        end else begin
`ifdef VAR_CYCLE_EN
          w_last = 1'b1;
          w_next = S_T1;
`endif
        end
      end
      S_T5: begin
        w_next = S_T6;
        if (r_op == OP_LDA) begin
          w_con_dec = 12'h2C3;
`ifdef VAR_CYCLE_EN
          w_last = 1'b1;
          w_next = S_T1;
`endif
        end else if (r_op == OP_ADD || r_op == OP_SUB) begin
          w_con_dec = 12'h2E1;
        end
      end
      S_T6: begin
        w_last = 1'b1;
        w_next = S_T1;
        if (r_op == OP_ADD) begin
          w_con_dec = 12'h3C7;
        end else if (r_op == OP_SUB) begin
          w_con_dec = 12'h3CF;
        end
      end
      default: begin
        w_next = S_T1;
      end
    endcase

    if (!w_adv) begin
      w_next      = r_state;
      w_halt_next = r_halted;
      w_op_next   = r_op;
    end

    // Idle the datapath on any rising edge that is not followed by an advance,
    // otherwise repeated rising edges would re-load or re-increment.
    con       = w_adv ? w_con_dec : IDLE_CON;
    cycle_end = w_last & ~r_halted;
  end

  assign tstate = r_state;
  assign halted = r_halted;

endmodule

// File: tb/tb_sap1_sequencer.sv
// tb/tb_sap1_sequencer.sv - randomized self-checking bench for sap1_sequencer
module tb_sap1_sequencer;

  logic        clk;
  logic        clr;
  logic [3:0]  opcode;
  logic        run;
  logic        step;
  logic [11:0] con;
  logic [5:0]  tstate;
  logic        halted;
  logic        cycle_end;

  int checks = 0;
  int errors = 0;

  logic [19:0] obs;
  logic [19:0] expv;

  // reference model: instruction position as an integer 0..6
  int         m_t;
  logic       m_halt;
  logic [3:0] m_op;
  logic       m_stepq;

  sap1_sequencer dut (
    .clk       (clk),
    .clr       (clr),
    .opcode    (opcode),
    .run       (run),
    .step      (step),
    .con       (con),
    .tstate    (tstate),
    .halted    (halted),
    .cycle_end (cycle_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int m_len(input logic [3:0] op);
`ifdef VAR_CYCLE_EN
    if (op == 4'h0) return 5;
    if (op == 4'h1 || op == 4'h2 || op == 4'hF) return 6;
    return 4;
`else
    return 6;
`endif
  endfunction

  function automatic logic m_will_adv();
    return !m_halt && (run || (step && !m_stepq));
  endfunction

  function automatic logic [11:0] exp_con();
    logic [35:0] w;
    if (!m_will_adv() || m_t == 0) return 12'h3E3;
    if (m_t == 1) return 12'h5E3;
    if (m_t == 2) return 12'hBE3;
    if (m_t == 3) return 12'h263;
    case (m_op)
      4'h0:    w = {12'h1A3, 12'h2C3, 12'h3E3};
      4'h1:    w = {12'h1A3, 12'h2E1, 12'h3C7};
      4'h2:    w = {12'h1A3, 12'h2E1, 12'h3CF};
      4'hE:    w = {12'h3F2, 12'h3E3, 12'h3E3};
      default: w = {12'h3E3, 12'h3E3, 12'h3E3};
    endcase
    return w[(6 - m_t) * 12 +: 12];
  endfunction

  function automatic logic [5:0] exp_ts();
    logic [5:0] one;
    one = 6'd1;
    return (m_t == 0) ? 6'd0 : (one << (m_t - 1));
  endfunction

  function automatic logic exp_ce();
    return !m_halt && m_t != 0 && m_t == m_len(m_op);
  endfunction

  task automatic model_reset();
    m_t = 0;
    m_halt = 1'b0;
    m_op = 4'h0;
    m_stepq = 1'b0;
  endtask

  // falling edge: advance the model with the inputs the DUT sampled
  task automatic tick();
    @(negedge clk);
    if (m_will_adv()) begin
      if (m_t == 3) m_op = opcode;
      if (m_t == 4 && m_op == 4'hF) begin
        m_halt = 1'b1;
        m_t = 5;
      end else if (m_t == 0 || m_t == m_len(m_op)) begin
        m_t = 1;
      end else begin
        m_t = m_t + 1;
      end
    end
    m_stepq = step;
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b0; run = 1'b1; step = 1'b0; opcode = 4'h0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      obs = {con, tstate, halted, cycle_end};
      checks++;
      if (obs !== {12'h3E3, 6'h00, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset cyc=%0d got=%h exp=%h", i, obs, {12'h3E3, 6'h00, 2'b00});
      end
    end
    clr = 1'b1;
    tick();
  endtask

  task automatic test_lda();
    opcode = 4'h0; run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      obs = {con, tstate, halted, cycle_end};
      expv = {exp_con(), exp_ts(), m_halt, exp_ce()};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL lda cyc=%0d got=%h exp=%h", i, obs, expv);
      end
      tick();
    end
  endtask

  task automatic test_sub();
    opcode = 4'h2; run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      obs = {con, tstate, halted, cycle_end};
      expv = {exp_con(), exp_ts(), m_halt, exp_ce()};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL sub cyc=%0d got=%h exp=%h", i, obs, expv);
      end
      tick();
    end
  endtask

  task automatic test_halt();
    opcode = 4'hF; run = 1'b1; step = 1'b0;
    for (int i = 0; i < 34; i++) begin
      if (i >= 10) begin
        run  = 1'($urandom_range(0, 1));
        step = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      obs = {con, tstate, halted, cycle_end};
      expv = {exp_con(), exp_ts(), m_halt, exp_ce()};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL halt cyc=%0d got=%h exp=%h", i, obs, expv);
      end
      tick();
    end
    checks++;
    if (tstate !== 6'b010000 || halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_frozen got ts=%b h=%b exp ts=010000 h=1", tstate, halted);
    end
    @(posedge clk); #1;
    clr = 1'b0; #1;
    obs = {con, tstate, halted, cycle_end};
    checks++;
    if (obs !== {12'h3E3, 6'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL halt_clr got=%h exp=%h", obs, {12'h3E3, 6'h00, 2'b00});
    end
    model_reset();
    #1 clr = 1'b1;
    run = 1'b0; step = 1'b0;
    tick();
  endtask

  task automatic test_step();
    opcode = 4'h1; run = 1'b1; step = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      obs = {con, tstate, halted, cycle_end};
      expv = {exp_con(), exp_ts(), m_halt, exp_ce()};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL step_pre cyc=%0d got=%h exp=%h", i, obs, expv);
      end
      tick();
    end
    run = 1'b0;
    checks++;
    if (tstate !== 6'b000010) begin
      errors++;
      $display("FAIL step_at_t2 got=%b exp=000010", tstate);
    end
    // three one-cycle pulses separated by one low cycle, then step held high
    for (int i = 0; i < 10; i++) begin
      step = (i < 6) ? ~i[0] : 1'b1;
      @(posedge clk); #1;
      obs = {con, tstate, halted, cycle_end};
      expv = {exp_con(), exp_ts(), m_halt, exp_ce()};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL step cyc=%0d got=%h exp=%h", i, obs, expv);
      end
      tick();
      if (i == 5) begin
        checks++;
        if (tstate !== 6'b010000) begin
          errors++;
          $display("FAIL step_after_pulses got=%b exp=010000", tstate);
        end
      end
    end
    checks++;
    if (tstate !== 6'b100000) begin
      errors++;
      $display("FAIL step_held got=%b exp=100000", tstate);
    end
    step = 1'b0;
  endtask

  task automatic test_async_clr();
    opcode = 4'h1; run = 1'b1; step = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      obs = {con, tstate, halted, cycle_end};
      expv = {exp_con(), exp_ts(), m_halt, exp_ce()};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL aclr_run cyc=%0d got=%h exp=%h", i, obs, expv);
      end
      if (m_t == 5) break;
      tick();
    end
    checks++;
    if (tstate !== 6'b010000) begin
      errors++;
      $display("FAIL aclr_reach_t5 got=%b exp=010000", tstate);
    end
    #1 clr = 1'b0;
    #1;
    obs = {con, tstate, halted, cycle_end};
    checks++;
    if (obs !== {12'h3E3, 6'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL aclr got=%h exp=%h", obs, {12'h3E3, 6'h00, 2'b00});
    end
    model_reset();
    #1 clr = 1'b1;
    tick();
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int i = 0; i < 400; i++) begin
      run    = ($urandom_range(0, 9) < 6);
      step   = 1'($urandom_range(0, 1));
      opcode = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
      obs = {con, tstate, halted, cycle_end};
      expv = {exp_con(), exp_ts(), m_halt, exp_ce()};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, obs, expv);
      end
      if (m_halt) hold++;
      if (hold > 3) begin
        #1 clr = 1'b0;
        #1;
        obs = {con, tstate, halted, cycle_end};
        checks++;
        if (obs !== {12'h3E3, 6'h00, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL random_clr cyc=%0d got=%h exp=%h", i, obs, {12'h3E3, 6'h00, 2'b00});
        end
        model_reset();
        hold = 0;
        #1 clr = 1'b1;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_lda();
    test_sub();
    test_halt();
    test_step();
    test_async_clr();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
